// File: rtl/fft_peak_scan.sv
// Post-frame peak search: walks a bin range of the FFT output RAM, squares each {Re, Im}
// word in a three-stage pipeline and reports the bin with the largest magnitude-squared.
module fft_peak_scan #(
  parameter int unsigned bit_width  = 16,
  parameter int unsigned addr_width = 5,
  parameter int unsigned first_bin  = 1,
  parameter int unsigned last_bin   = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2*bit_width-1:0]   min_mag,
  output logic [addr_width-1:0]    rd_addr,
  output logic                     rd_en,
  input  logic [2*bit_width-1:0]   rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [addr_width-1:0]    peak_bin,
  output logic [2*bit_width-1:0]   peak_mag,
  output logic                     peak_valid
);

  localparam int unsigned MagW = 2 * bit_width;
  localparam logic [addr_width-1:0] FirstAddr = addr_width'(first_bin);
  localparam logic [addr_width-1:0] LastAddr  = addr_width'(last_bin);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e                 state_q;
  logic [MagW-1:0]        min_mag_q;
  logic [MagW-1:0]        max_mag_q;
  logic [addr_width-1:0]  max_bin_q;

  // S1: RAM word on rd_data, tagged with the address issued one cycle earlier.
  logic                   s1_valid_q;
  logic [addr_width-1:0]  s1_bin_q;
  // S2: registered magnitude-squared.
  logic                   s2_valid_q;
  logic [addr_width-1:0]  s2_bin_q;
  logic [MagW-1:0]        s2_mag_q;
  // S3: running max has absorbed the S2 value.
  logic                   s3_valid_q;

  logic signed [bit_width-1:0] re, im;
  logic signed [MagW-1:0]      re_ext, im_ext;
  logic        [MagW-1:0]      re_sq, im_sq, sq_sum;

  // Each square is at most 2^(MagW-2), so the unsigned sum cannot overflow.
  always_comb begin
    re     = rd_data[MagW-1:bit_width];
    im     = rd_data[bit_width-1:0];
    re_ext = MagW'(re);
    im_ext = MagW'(im);
    re_sq  = $unsigned(re_ext * re_ext);
    im_sq  = $unsigned(im_ext * im_ext);
    sq_sum = re_sq + im_sq;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_mag_q   <= '0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_en;
      s1_bin_q   <= rd_addr;
      s2_valid_q <= s1_valid_q;
      s2_bin_q   <= s1_bin_q;
      s2_mag_q   <= sq_sum;
      s3_valid_q <= s2_valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
      min_mag_q  <= '0;
      max_mag_q  <= '0;
      max_bin_q  <= '0;
    end else begin
      done <= 1'b0;
      // Strictly greater keeps the lowest index on ties.
      if (s2_valid_q && (s2_mag_q > max_mag_q)) begin
        max_mag_q <= s2_mag_q;
        max_bin_q <= s2_bin_q;
      end
      unique case (state_q)
        StIdle: begin
          busy <= 1'b0;
          if (start) begin
            min_mag_q <= min_mag;
            max_mag_q <= '0;
            max_bin_q <= FirstAddr;
            rd_en     <= 1'b1;
            rd_addr   <= FirstAddr;
            busy      <= 1'b1;
            state_q   <= StScan;
          end
        end
        StScan: begin
          if (rd_addr == LastAddr) begin
            rd_en   <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        StDrain: begin
          // Last bin merged into the running max on the previous edge.
          if (s3_valid_q && !s2_valid_q) begin
            done       <= 1'b1;
            peak_bin   <= max_bin_q;
            peak_mag   <= max_mag_q;
            peak_valid <= (max_mag_q >= min_mag_q);
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_scan.sv
// Self-checking bench for fft_peak_scan: directed table, corner sequences and random frames
// checked against a plain arithmetic peak search over a RAM model.
module tb_fft_peak_scan;

  localparam int FIRST = 1;
  localparam int LAST  = 15;
  localparam int NBINS = LAST - FIRST + 1;
  localparam int LAT   = NBINS + 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] min_mag = '0;
  logic [4:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data = '0;
  logic        busy, done, peak_valid;
  logic [4:0]  peak_bin;
  logic [31:0] peak_mag;

  logic        start1 = 1'b0;
  logic [4:0]  rd_addr1;
  logic        rd_en1;
  logic [31:0] rd_data1 = '0;
  logic        busy1, done1, peak_valid1;
  logic [4:0]  peak_bin1;
  logic [31:0] peak_mag1;

  logic [31:0] ram [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_peak_scan #(.bit_width(16), .addr_width(5), .first_bin(FIRST), .last_bin(LAST)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .min_mag(min_mag),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .busy(busy), .done(done),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid)
  );

  fft_peak_scan #(.bit_width(16), .addr_width(5), .first_bin(4), .last_bin(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .min_mag(32'd0),
    .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1), .busy(busy1), .done(done1),
    .peak_bin(peak_bin1), .peak_mag(peak_mag1), .peak_valid(peak_valid1)
  );

  // Synchronous-read RAM with one cycle of latency.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= ram[rd_addr];
    if (rd_en1) rd_data1 <= ram[rd_addr1];
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: largest Re^2+Im^2 over the scanned range, first occurrence wins.
  task automatic model(input longint mm, output int b, output longint m, output bit v);
    longint re, im, cur;
    b = FIRST;
    m = 0;
    for (int i = FIRST; i <= LAST; i++) begin
      re  = longint'($signed(ram[i][31:16]));
      im  = longint'($signed(ram[i][15:0]));
      cur = re * re + im * im;
      if (cur > m) begin
        m = cur;
        b = i;
      end
    end
    v = (m >= mm);
  endtask

  // Pulses start and follows the scan until done, logging reads and busy.
  task automatic run_scan(input logic [31:0] mm, output int lat, output int nreads,
                          output bit addr_ok, output bit busy_ok);
    @(negedge clk);
    start   = 1'b1;
    min_mag = mm;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    nreads  = 0;
    addr_ok = 1'b1;
    busy_ok = 1'b1;
    while (1) begin
      if (rd_en) begin
        if (int'(rd_addr) != FIRST + nreads) addr_ok = 1'b0;
        nreads++;
      end
      if (!busy) busy_ok = 1'b0;
      if (done || lat >= 100) break;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) $display("FAIL scan_timeout: got no done after %0d cycles expected %0d", lat, LAT);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  bin_a;
    logic [31:0] word_a;
    logic [4:0]  bin_b;
    logic [31:0] word_b;
    logic [31:0] bg;
    logic [31:0] mm;
    logic [4:0]  exp_bin;
    logic [31:0] exp_mag;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int     lat, nreads, b, ndone, first_done;
    bit     addr_ok, busy_ok, v, seen_bad;
    longint m;
    int     done_at[$];

    vecs[0] = '{"single_peak", 5'd7,  32'h012C_FE70, 5'd7, 32'h012C_FE70, 32'h000A_000A,
                32'd250000, 5'd7, 32'd250000, 1'b1};
    vecs[1] = '{"tie", 5'd3, 32'h03E8_0000, 5'd9, 32'h03E8_0000, 32'h0,
                32'd1000001, 5'd3, 32'd1000000, 1'b0};
    vecs[2] = '{"extreme", 5'd12, 32'h8000_8000, 5'd12, 32'h8000_8000, 32'h0,
                32'h8000_0000, 5'd12, 32'h8000_0000, 1'b1};
    vecs[3] = '{"all_zero", 5'd0, 32'h0, 5'd0, 32'h0, 32'h0,
                32'd1, 5'd1, 32'd0, 1'b0};

    for (int i = 0; i < 32; i++) ram[i] = '0;

    // Reset state, then idle with no start.
    #12;
    check("reset_rd_en", rd_en, 0);
    check("reset_busy", busy, 0);
    check("reset_peak", {peak_bin, peak_mag, peak_valid, done}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rd_en || done || busy) seen_bad = 1'b1;
    end
    check("idle_quiet", seen_bad, 0);

    // Directed table.
    foreach (vecs[k]) begin
      for (int i = 0; i < 32; i++) ram[i] = vecs[k].bg;
      ram[vecs[k].bin_b] = vecs[k].word_b;
      ram[vecs[k].bin_a] = vecs[k].word_a;
      run_scan(vecs[k].mm, lat, nreads, addr_ok, busy_ok);
      check({vecs[k].name, "_latency"}, lat, LAT);
      check({vecs[k].name, "_reads"}, nreads, NBINS);
      check({vecs[k].name, "_addr_seq"}, addr_ok, 1);
      check({vecs[k].name, "_busy"}, busy_ok, 1);
      check({vecs[k].name, "_bin"}, peak_bin, vecs[k].exp_bin);
      check({vecs[k].name, "_mag"}, peak_mag, vecs[k].exp_mag);
      check({vecs[k].name, "_valid"}, peak_valid, vecs[k].exp_valid);
      model(vecs[k].mm, b, m, v);
      check({vecs[k].name, "_model_mag"}, peak_mag, m);
    end

    // Outputs hold after done; busy drops the cycle after done.
    repeat (3) @(negedge clk);
    check("hold_mag", peak_mag, 0);
    check("hold_bin", peak_bin, FIRST);
    check("idle_busy", busy, 0);
    check("done_pulse", done, 0);

    // Start re-pulsed mid-scan and in DRAIN is ignored.
    for (int i = 0; i < 32; i++) ram[i] = 32'h000A_000A;
    ram[7] = 32'h012C_FE70;
    @(negedge clk);
    start   = 1'b1;
    min_mag = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    first_done = -1;
    for (int t = 0; t <= 60; t++) begin
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = t;
      end
      start = (t == 4 || t == 17);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("repulse_done_count", ndone, 1);
    check("repulse_latency", first_done, LAT);
    check("repulse_bin", peak_bin, 7);

    // Start held high: back-to-back scans every LAT+1 cycles.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 80; t++) begin
      if (done) done_at.push_back(t);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("held_done_count", done_at.size(), 4);
    if (done_at.size() >= 3) begin
      check("held_first", done_at[0], LAT);
      check("held_period1", done_at[1] - done_at[0], LAT + 1);
      check("held_period2", done_at[2] - done_at[1], LAT + 1);
    end
    for (int t = 0; t < 40 && busy; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("held_drain_idle", busy, 0);

    // Abort by reset when rd_addr reaches 6.
    @(negedge clk);
    start = 1'b1;
    min_mag = 32'd0;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 30 && !(rd_en && rd_addr == 5'd6); t++) @(negedge clk);
    check("abort_reach_6", rd_addr, 6);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_rd_en", rd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_peak", {peak_bin, peak_mag, peak_valid}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || rd_en) ndone++;
    end
    check("abort_no_done", ndone, 0);
    for (int i = 0; i < 32; i++) ram[i] = '0;
    ram[5] = 32'h0064_FF9C;
    run_scan(32'd20000, lat, nreads, addr_ok, busy_ok);
    check("after_abort_latency", lat, LAT);
    check("after_abort_addr", addr_ok, 1);
    check("after_abort_bin", peak_bin, 5);
    check("after_abort_mag", peak_mag, 20000);
    check("after_abort_valid", peak_valid, 1);

    // Single-bin range on the second instance.
    ram[4] = 32'h0003_0004;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    lat = 0;
    nreads = 0;
    while (!done1 && lat < 40) begin
      if (rd_en1) nreads++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("single_bin_latency", lat, 4);
    check("single_bin_reads", nreads, 1);
    check("single_bin_bin", peak_bin1, 4);
    check("single_bin_mag", peak_mag1, 25);

    // Random frames against the model.
    for (int r = 0; r < 16; r++) begin
      logic [31:0] mm;
      for (int i = 0; i < 32; i++) begin
        if (r % 2 == 0) ram[i] = {16'($signed($urandom_range(0, 6)) - 3),
                                  16'($signed($urandom_range(0, 6)) - 3)};
        else            ram[i] = $urandom;
      end
      model(0, b, m, v);
      case (r % 4)
        0: mm = 32'(m);
        1: mm = 32'(m + 1);
        2: mm = (m > 0) ? 32'(m - 1) : 32'd0;
        default: mm = $urandom;
      endcase
      model(longint'(mm), b, m, v);
      run_scan(mm, lat, nreads, addr_ok, busy_ok);
      check($sformatf("rand%0d_latency", r), lat, LAT);
      check($sformatf("rand%0d_bin", r), peak_bin, b);
      check($sformatf("rand%0d_mag", r), peak_mag, m);
      check($sformatf("rand%0d_valid", r), peak_valid, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_scan.md
Name: fft_peak_scan

Overview:
Sequencer that runs after each FFT frame completes. It walks the FFT output RAM over a configurable bin range and computes Re^2+Im^2 for each bin in a registered pipeline. It tracks the largest magnitude-squared and reports that bin index to the tuner note-decode logic, with a one-cycle done pulse and a threshold-qualified valid flag.

Parameters:
bit_width, 16, signed width of each Re/Im component; RAM word is {Re, Im}, 2*bit_width bits
addr_width, 5, FFT RAM address width; FFT length N = 2^addr_width
first_bin, 1, first bin scanned (skips DC)
last_bin, 15, last bin scanned (N/2-1 by default); first_bin <= last_bin < N is required

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  frame-ready strobe from FFT control; sampled only in IDLE
min_mag  in  2*bit_width  unsigned threshold for peak_valid; sampled at start
rd_addr  out  addr_width  FFT RAM read address
rd_en  out  1  FFT RAM read enable
rd_data  in  2*bit_width  {Re, Im}; valid exactly 1 cycle after rd_en/rd_addr
busy  out  1  high from the start edge until done, inclusive
done  out  1  one-cycle pulse; peak outputs are final in this cycle
peak_bin  out  addr_width  index of the maximum bin
peak_mag  out  2*bit_width  magnitude-squared of peak_bin
peak_valid  out  1  peak_mag >= latched min_mag

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rd_en=0, rd_addr=0, busy=0, done=0, peak_bin=0, peak_mag=0, peak_valid=0; pipeline valid bits cleared. Asserting reset mid-scan aborts the scan immediately with no done pulse.
- States: IDLE -> SCAN -> DRAIN -> IDLE.
  - IDLE: start=1 at an edge latches min_mag, clears the running max to 0 and the running index to first_bin, and enters SCAN.
  - SCAN: rd_en=1; rd_addr=first_bin on the first SCAN cycle, +1 per cycle. The cycle with rd_addr=last_bin is the last SCAN cycle; next state is DRAIN.
  - DRAIN: rd_en=0; wait for the 3-stage pipeline to empty, then pulse done and return to IDLE.
- Pipeline (each stage has its own valid bit and carries the bin index):
  - S1: rd_data and its bin index arrive (RAM latency 1).
  - S2: register re*re + im*im, signed squares. Max sum is 2^(2*bit_width-1), so it fits 2*bit_width bits unsigned with no truncation.
  - S3: compare the S2 value against the running max. Strictly greater replaces the max and the index, so ties keep the lowest index.
- Latency: with M = last_bin-first_bin+1, done is high exactly M+3 clocks after the start edge. Default M=15 gives done at edge 18.
- Outputs:
  - peak_bin, peak_mag and peak_valid are registered and update only in the done cycle.
  - They hold their values until the next done or reset.
  - peak_valid = (peak_mag >= min_mag latched at start).
- busy: high from the cycle after the start edge through the done cycle; low in IDLE.
- start while busy (SCAN/DRAIN/done cycle): ignored, with no restart and no queueing. start held high continuously re-triggers one cycle after each done.
- All-zero frame: peak_bin=first_bin, peak_mag=0.
- first_bin=last_bin: single read; done at start edge +4.
- rd_addr holds its last value during DRAIN/IDLE; only rd_en qualifies reads.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> all outputs 0 immediately; start never pulsed -> rd_en stays 0, done never asserts.
- Single peak: RAM bin7={300,-400}, others {10,10}, start pulse -> rd_addr 1..15 on consecutive cycles, done exactly 18 clocks after start, peak_bin=7, peak_mag=250000.
- Tie: bins 3 and 9 both {1000,0}, rest 0 -> peak_bin=3, peak_mag=1000000.
- Extremes/threshold: bin12={-32768,-32768}, min_mag=0x8000_0000 -> peak_mag=0x8000_0000, peak_valid=1. All-zero frame with min_mag=1 -> peak_bin=1, peak_mag=0, peak_valid=0.
- Busy handling: start re-pulsed at cycles 5 and 17 of a scan -> ignored, exactly one done. Start held high -> back-to-back scans with done every 19 cycles.
- Abort: reset_n low during SCAN at rd_addr=6, released, then new start -> no done from the aborted scan; new scan begins at first_bin and reports the correct peak.
